cc2420_spi_master: RTL and testbench
====================================

Name: cc2420_spi_master

Overview:
- Byte-level SPI master for the CC2420 radio; the responder end of the Command/InValid/InRequest handshake driven by the radio init and control FSMs.
- Requests a byte with a one-cycle InRequest pulse and serializes the accepted Command MSB-first in SPI mode 0.
- Returns the byte clocked in on MISO as SO.
- Frames multi-byte transactions with CSn; a request answered with InValid low closes the frame.

Parameters:
CLK_DIV, 4, SCLK half-period in Clock cycles (>=1); SCLK = Clock/(2*CLK_DIV)
CS_HIGH, 4, minimum CSn-high cycles between frames and after reset (>=1)

Ports:
Clock  input  1  system clock
Reset  input  1  synchronous, active-high reset
InValid  input  1  requester has a byte for this request; sampled only on InRequest cycles
Command  input  8  byte to transmit; sampled with InValid
InRequest  output  1  single-cycle pulse; requester must present InValid/Command combinationally this cycle
SO  output  8  last byte received on MISO; registered, holds until the next byte completes
SCLK  output  1  SPI clock, idles low
CSn  output  1  chip select, active low
SI  output  1  MOSI to radio
MISO  input  1  radio SO pin

Behaviour:
- Interface fixed: one clock, Clock; synchronous active-high reset, Reset.
- Reset values: CSn=1, SCLK=0, SI=0, SO=8'h00, InRequest=0. Reset mid-byte aborts immediately; the partial byte is discarded and CSn is high the next cycle.
- States: GAP, REQ, LEAD, HIGH, LOW, DONE.
- GAP:
  - Entered from reset and at frame close.
  - CSn=1 for CS_HIGH cycles, then REQ.
- REQ (one cycle):
  - InRequest=1.
  - InValid=1: latch Command into the shift register, SI=Command[7], CSn=0 next cycle, go to LEAD.
  - InValid=0: if CSn=0, the frame closes (CSn=1 next cycle, GAP). If CSn=1, go to GAP, so REQ re-pulses every CS_HIGH+1 cycles while idle.
- LEAD: SCLK=0 for CLK_DIV cycles (SI setup).
- HIGH:
  - SCLK=1 for CLK_DIV cycles.
  - MISO is sampled into the receive shift register (MSB first) on the cycle SCLK rises.
- LOW:
  - SCLK=0 for CLK_DIV cycles.
  - SI is updated to the next bit on the cycle SCLK falls.
  - After bit 0's LOW phase go to DONE; otherwise go to HIGH.
- DONE:
  - SO is loaded with the received byte.
  - Same transition as REQ: InRequest pulses this cycle.
  - CSn stays low while further bytes are accepted back-to-back.
- Byte latency: 17*CLK_DIV cycles from the REQ/DONE accept cycle to the next DONE.
- SO is valid on and after every InRequest pulse; the requester may branch on SO bits (e.g. status bit 6) in the pulse cycle.
- SI holds its last bit while idle; it does not matter with CSn high.
- Bit counter is 3 bits and the divider counter is clog2(CLK_DIV)+1 bits; neither wraps outside its phase.
- InValid/Command outside InRequest cycles are ignored.
- Never more than one InRequest pulse per byte period or gap.

Optional Feature:
- Macro CC2420_SPI_LOOPBACK_EN.
- Defined: an extra input LoopBack (1 bit) exists; when it is 1, the receive shift register samples SI instead of MISO, so SO equals the previously transmitted byte. Pins are still driven normally.
- Undefined: no LoopBack port; MISO is always sampled.

Test Plan:
- Reset released, InValid=0 held -> CSn stays 1, SCLK stays 0; InRequest pulses at cycle 4, then every 5 cycles (CLK_DIV=4, CS_HIGH=4).
- Single byte 8'h01 accepted, MISO model returns 8'h40 -> CSn low for 68 cycles; 8 SCLK rising edges with SI=0,0,0,0,0,0,0,1; SO=8'h40 at the next InRequest; InValid=0 there -> CSn high next cycle for 4 cycles.
- Three-byte frame 8'h11, 8'h02, 8'hE2 answered back-to-back -> CSn continuously low across 204 cycles, 24 SCLK pulses, no gap; CSn rises only after the 4th request answers InValid=0.
- Requester polls with 8'h00 until SO[6]=1 (model returns 8'h00 twice, then 8'h40) -> exactly 3 bytes shifted, each ending with an InRequest pulse with SO updated.
- Reset asserted at bit 4 of byte 8'hA5 -> CSn=1, SCLK=0, SO=8'h00 next cycle; after release, first InRequest after 4 cycles.
- CC2420_SPI_LOOPBACK_EN, LoopBack=1, send 8'h97 then 8'h00 in one frame -> SO=8'h97 after byte 1, 8'h00 after byte 2.

Source files
------------

// File: rtl/cc2420_spi_master.sv
// cc2420_spi_master: byte-level SPI master (mode 0, MSB first) for the CC2420.
// Pulls bytes from a requester through a one-cycle InRequest handshake; the
// requester answers combinationally with InValid/Command in that cycle.
// A request answered with InValid low closes the current CSn frame.
//
// Ports:
//   Clock, Reset      system clock, synchronous active-high reset
//   InValid, Command  requester reply, sampled only while InRequest is high
//   InRequest         one-cycle request pulse
//   SO                last byte received on MISO (registered)
//   SCLK, CSn, SI     SPI pins driven to the radio
//   MISO              radio SO pin
//   LoopBack          only with CC2420_SPI_LOOPBACK_EN: receive SI instead of MISO
//
// Optional feature macro: CC2420_SPI_LOOPBACK_EN (undefined by default).
`timescale 1ns/1ps

module cc2420_spi_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_HIGH = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       InValid,
  input  logic [7:0] Command,
  output logic       InRequest,
  output logic [7:0] SO,
  output logic       SCLK,
  output logic       CSn,
  output logic       SI,
`ifdef CC2420_SPI_LOOPBACK_EN
  input  logic       LoopBack,
`endif
  input  logic       MISO
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;
  localparam int unsigned GAP_W = $clog2(CS_HIGH) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  // The DONE cycle doubles as the last low cycle of bit 0, so that phase is
  // one cycle shorter; this keeps a byte at exactly 17*CLK_DIV cycles.
  localparam logic [DIV_W-1:0] DIV_LAST_FINAL = DIV_W'((CLK_DIV > 1) ? (CLK_DIV - 2) : 0);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_HIGH - 1);

  typedef enum logic [2:0] {
    ST_GAP,
    ST_REQ,
    ST_LEAD,
    ST_HIGH,
    ST_LOW,
    ST_DONE
  } state_t;

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [6:0]       tx;       // bits still to send after the one on SI
  logic [7:0]       rx;
  logic             rx_bit;

  // Receive source select
`ifdef CC2420_SPI_LOOPBACK_EN
  assign rx_bit = LoopBack ? SI : MISO;
`else
  assign rx_bit = MISO;
`endif

  // Control FSM with registered pin outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= ST_GAP;
      gap_cnt   <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      tx        <= '0;
      rx        <= '0;
      InRequest <= 1'b0;
      SO        <= 8'h00;
      SCLK      <= 1'b0;
      CSn       <= 1'b1;
      SI        <= 1'b0;
    end else begin
      InRequest <= 1'b0;
      case (state)
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state     <= ST_REQ;
            InRequest <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        // REQ and DONE share the accept/close decision
        ST_REQ, ST_DONE: begin
          if (InValid) begin
            tx      <= Command[6:0];
            SI      <= Command[7];
            CSn     <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= ST_LEAD;
          end else begin
            CSn     <= 1'b1;
            gap_cnt <= '0;
            state   <= ST_GAP;
          end
        end

        ST_LEAD: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            SCLK    <= 1'b1;
            rx      <= {rx[6:0], rx_bit};
            state   <= ST_HIGH;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        ST_HIGH: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            SCLK    <= 1'b0;
            if (bit_cnt == 3'd7) begin
              // Last bit: SI holds; with CLK_DIV=1 the final low phase is empty
              if (CLK_DIV == 1) begin
                SO        <= rx;
                InRequest <= 1'b1;
                state     <= ST_DONE;
              end else begin
                state <= ST_LOW;
              end
            end else begin
              SI    <= tx[6];
              tx    <= {tx[5:0], 1'b0};
              state <= ST_LOW;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        ST_LOW: begin
          if (bit_cnt == 3'd7) begin
            if (div_cnt == DIV_LAST_FINAL) begin
              div_cnt   <= '0;
              SO        <= rx;
              InRequest <= 1'b1;
              state     <= ST_DONE;
            end else begin
              div_cnt <= div_cnt + DIV_W'(1);
            end
          end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + 3'd1;
            SCLK    <= 1'b1;
            rx      <= {rx[6:0], rx_bit};
            state   <= ST_HIGH;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: begin
          CSn     <= 1'b1;
          SCLK    <= 1'b0;
          gap_cnt <= '0;
          state   <= ST_GAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cc2420_spi_master.sv
// tb_cc2420_spi_master: directed bench for cc2420_spi_master (CLK_DIV=4, CS_HIGH=4).
// Acts as requester and as a mode-0 radio that shifts MISO on falling SCLK.
`timescale 1ns/1ps

module tb_cc2420_spi_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] command = 8'h00;
  logic       in_request;
  logic [7:0] so;
  logic       sclk;
  logic       csn;
  logic       si;
  logic       miso;
`ifdef CC2420_SPI_LOOPBACK_EN
  logic       loop_back = 1'b0;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  // Radio MISO model
  logic [7:0]  miso_byte = 8'h00;
  int unsigned fall_cnt = 0;
  int unsigned miso_base = 0;
  int unsigned miso_idx;

  // Monitor state (written only by the monitor)
  logic       sclk_d = 1'b0;
  int         sclk_rises = 0;
  logic [7:0] si_hist = 8'h00;
  int         low_run = 0;
  int         last_low = 0;
  int         csn_low_total = 0;

  logic [7:0] poll_resp [3] = '{8'h00, 8'h00, 8'h40};

  cc2420_spi_master #(.CLK_DIV(4), .CS_HIGH(4)) dut (
    .Clock(clk),
    .Reset(rst),
    .InValid(in_valid),
    .Command(command),
    .InRequest(in_request),
    .SO(so),
    .SCLK(sclk),
    .CSn(csn),
    .SI(si),
`ifdef CC2420_SPI_LOOPBACK_EN
    .LoopBack(loop_back),
`endif
    .MISO(miso)
  );

  always #5 clk = ~clk;

  always @(negedge sclk) fall_cnt <= fall_cnt + 1;

  assign miso_idx = fall_cnt - miso_base;
  assign miso = (miso_idx < 8) ? miso_byte[3'(7 - miso_idx)] : 1'b0;

  // Samples the cycle that just ended
  always @(posedge clk) begin
    sclk_d <= sclk;
    if (sclk === 1'b1 && sclk_d === 1'b0) begin
      sclk_rises <= sclk_rises + 1;
      si_hist    <= {si_hist[6:0], si};
    end
    if (csn === 1'b0) begin
      low_run       <= low_run + 1;
      csn_low_total <= csn_low_total + 1;
    end else begin
      if (low_run != 0) last_low <= low_run;
      low_run <= 0;
    end
  end

  // Waits for an InRequest pulse; n = negedges waited, -1 on timeout
  task automatic wait_req(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (in_request === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Answers the current request (called at the negedge of a pulse cycle)
  task automatic answer(input logic v, input logic [7:0] cmd, input logic [7:0] rbyte);
    in_valid = v;
    command  = cmd;
    if (v) begin
      miso_byte = rbyte;
      miso_base = fall_cnt;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    command  = 8'h00;
  endtask

  task automatic test_reset();
    int n;
    int low0;
    int rise0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (csn !== 1'b1) begin n_fail++; $display("FAIL reset_csn: got %b want 1", csn); end
    n_cmp++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    n_cmp++; if (si !== 1'b0) begin n_fail++; $display("FAIL reset_si: got %b want 0", si); end
    n_cmp++; if (so !== 8'h00) begin n_fail++; $display("FAIL reset_so: got %h want 00", so); end
    n_cmp++; if (in_request !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", in_request); end
    low0  = csn_low_total;
    rise0 = sclk_rises;
    rst = 1'b0;
    wait_req(n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL idle_first_req: got %0d want 4", n); end
    for (int k = 0; k < 2; k++) begin
      answer(1'b0, 8'hFF, 8'h00);
      wait_req(n);
      n_cmp++; if (n !== 5) begin n_fail++; $display("FAIL idle_req_period: got %0d want 5", n); end
    end
    n_cmp++; if (csn_low_total != low0) begin n_fail++; $display("FAIL idle_csn_low: got %0d low cycles want 0", csn_low_total - low0); end
    n_cmp++; if (sclk_rises != rise0) begin n_fail++; $display("FAIL idle_sclk: got %0d rises want 0", sclk_rises - rise0); end
  endtask

  task automatic test_single_byte();
    int n;
    int rise0;
    rise0 = sclk_rises;
    answer(1'b1, 8'h01, 8'h40);
    wait_req(n);
    n_cmp++; if (n !== 68) begin n_fail++; $display("FAIL single_latency: got %0d want 68", n); end
    n_cmp++; if (so !== 8'h40) begin n_fail++; $display("FAIL single_so: got %h want 40", so); end
    n_cmp++; if (si_hist !== 8'h01) begin n_fail++; $display("FAIL single_si_bits: got %h want 01", si_hist); end
    n_cmp++; if (sclk_rises - rise0 != 8) begin n_fail++; $display("FAIL single_rises: got %0d want 8", sclk_rises - rise0); end
    n_cmp++; if (csn !== 1'b0) begin n_fail++; $display("FAIL single_csn_done: got %b want 0", csn); end
    answer(1'b0, 8'h00, 8'h00);
    n_cmp++; if (csn !== 1'b1) begin n_fail++; $display("FAIL single_csn_close: got %b want 1", csn); end
    wait_req(n);
    n_cmp++; if (n !== 5) begin n_fail++; $display("FAIL single_gap: got %0d want 5", n); end
    n_cmp++; if (last_low !== 68) begin n_fail++; $display("FAIL single_csn_low_len: got %0d want 68", last_low); end
  endtask

  task automatic test_back_to_back();
    int n;
    int rise0;
    rise0 = sclk_rises;
    answer(1'b1, 8'h11, 8'hA1);
    wait_req(n);
    n_cmp++; if (n !== 68) begin n_fail++; $display("FAIL b2b_lat1: got %0d want 68", n); end
    n_cmp++; if (so !== 8'hA1) begin n_fail++; $display("FAIL b2b_so1: got %h want a1", so); end
    n_cmp++; if (si_hist !== 8'h11) begin n_fail++; $display("FAIL b2b_si1: got %h want 11", si_hist); end
    answer(1'b1, 8'h02, 8'h3C);
    wait_req(n);
    n_cmp++; if (n !== 68) begin n_fail++; $display("FAIL b2b_lat2: got %0d want 68", n); end
    n_cmp++; if (so !== 8'h3C) begin n_fail++; $display("FAIL b2b_so2: got %h want 3c", so); end
    n_cmp++; if (si_hist !== 8'h02) begin n_fail++; $display("FAIL b2b_si2: got %h want 02", si_hist); end
    answer(1'b1, 8'hE2, 8'h5A);
    wait_req(n);
    n_cmp++; if (n !== 68) begin n_fail++; $display("FAIL b2b_lat3: got %0d want 68", n); end
    n_cmp++; if (so !== 8'h5A) begin n_fail++; $display("FAIL b2b_so3: got %h want 5a", so); end
    n_cmp++; if (si_hist !== 8'hE2) begin n_fail++; $display("FAIL b2b_si3: got %h want e2", si_hist); end
    answer(1'b0, 8'h00, 8'h00);
    wait_req(n);
    n_cmp++; if (n !== 5) begin n_fail++; $display("FAIL b2b_gap: got %0d want 5", n); end
    n_cmp++; if (last_low !== 204) begin n_fail++; $display("FAIL b2b_csn_low_len: got %0d want 204", last_low); end
    n_cmp++; if (sclk_rises - rise0 != 24) begin n_fail++; $display("FAIL b2b_rises: got %0d want 24", sclk_rises - rise0); end
  endtask

  task automatic test_status_poll();
    int n;
    int bytes;
    bit done;
    bytes = 0;
    done  = 1'b0;
    for (int k = 0; k < 6 && !done; k++) begin
      answer(1'b1, 8'h00, poll_resp[k > 2 ? 2 : k]);
      wait_req(n);
      bytes++;
      n_cmp++; if (n !== 68) begin n_fail++; $display("FAIL poll_latency: byte %0d got %0d want 68", k, n); end
      n_cmp++; if (so !== poll_resp[k > 2 ? 2 : k]) begin n_fail++; $display("FAIL poll_so: byte %0d got %h want %h", k, so, poll_resp[k > 2 ? 2 : k]); end
      if (so[6] === 1'b1 || n < 0) done = 1'b1;
    end
    answer(1'b0, 8'h00, 8'h00);
    n_cmp++; if (bytes !== 3) begin n_fail++; $display("FAIL poll_bytes: got %0d want 3", bytes); end
    wait_req(n);
    n_cmp++; if (n !== 5) begin n_fail++; $display("FAIL poll_gap: got %0d want 5", n); end
  endtask

  task automatic test_reset_mid_byte();
    int n;
    answer(1'b1, 8'hA5, 8'hFF);
    repeat (30) @(negedge clk);
    n_cmp++; if (sclk !== 1'b1 || csn !== 1'b0) begin n_fail++; $display("FAIL midrst_pre: got sclk=%b csn=%b want 1/0", sclk, csn); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (csn !== 1'b1) begin n_fail++; $display("FAIL midrst_csn: got %b want 1", csn); end
    n_cmp++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL midrst_sclk: got %b want 0", sclk); end
    n_cmp++; if (so !== 8'h00) begin n_fail++; $display("FAIL midrst_so: got %h want 00", so); end
    rst = 1'b0;
    wait_req(n);
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL midrst_first_req: got %0d want 4", n); end
  endtask

`ifdef CC2420_SPI_LOOPBACK_EN
  task automatic test_loopback();
    int n;
    loop_back = 1'b1;
    answer(1'b1, 8'h97, 8'hFF);
    wait_req(n);
    n_cmp++; if (so !== 8'h97) begin n_fail++; $display("FAIL loop_so1: got %h want 97", so); end
    answer(1'b1, 8'h00, 8'hFF);
    wait_req(n);
    n_cmp++; if (so !== 8'h00) begin n_fail++; $display("FAIL loop_so2: got %h want 00", so); end
    answer(1'b0, 8'h00, 8'h00);
    wait_req(n);
    n_cmp++; if (n !== 5) begin n_fail++; $display("FAIL loop_gap: got %0d want 5", n); end
    loop_back = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_status_poll();
    test_reset_mid_byte();
`ifdef CC2420_SPI_LOOPBACK_EN
    test_loopback();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
